// File: rtl/sample_byte_packer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : scope_pkg
//  Description : Shared types, widths and the sample packing helper for the
//                sample byte packer.
//  Revision    : 1.0 - initial release
// ============================================================================
package scope_pkg;

    localparam int SAMPLE_W         = 12;
    localparam int BYTES_PER_SAMPLE = 3;
    localparam int PACKED_W         = 8 * BYTES_PER_SAMPLE;

    // Serializer states; IDLE means nothing is held for output.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        B0   = 2'd1,
        B1   = 2'd2,
        B2   = 2'd3
    } ser_state_t;

    // Channel 1 occupies the upper 12 bits so the bytes come out MSB first.
    function automatic logic [PACKED_W-1:0] pack(input logic [SAMPLE_W-1:0] c1,
                                                 input logic [SAMPLE_W-1:0] c2);
        return {c1, c2};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sample_byte_packer_if.sv
`default_nettype none
// ============================================================================
//  Module      : sample_byte_packer_if
//  Description : Sample input, byte stream output and status signals of the
//                sample byte packer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sample_byte_packer_if;
    import scope_pkg::*;

    logic                sample_valid;
    logic [SAMPLE_W-1:0] data_ch1;
    logic [SAMPLE_W-1:0] data_ch2;
    logic [7:0]          out_data;
    logic                out_valid;
    logic                out_ready;
    logic                overflow;
    logic [7:0]          drop_count;
    logic                busy;

    // Packer side.
    modport slave (
        input  sample_valid, data_ch1, data_ch2, out_ready,
        output out_data, out_valid, overflow, drop_count, busy
    );

    // Producer/consumer side.
    modport master (
        output sample_valid, data_ch1, data_ch2, out_ready,
        input  out_data, out_valid, overflow, drop_count, busy
    );

endinterface
`default_nettype wire

// File: rtl/sample_byte_packer_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sample_fifo
//  Description : Show-ahead FIFO of packed samples. Pointers carry one extra
//                wrap bit to tell full from empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module sample_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             wr_en,
    input  wire logic [WIDTH-1:0] wr_data,
    input  wire logic             rd_en,
    output logic      [WIDTH-1:0] rd_data,
    output logic                  full,
    output logic                  empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;

    // Pointer advance; the caller never writes a full FIFO without popping.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (wr_en) r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
    end

    assign rd_data = r_mem[r_rd_ptr[AW-1:0]];
    assign empty   = (r_wr_ptr == r_rd_ptr);
    assign full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

endmodule
`default_nettype wire

// File: rtl/sample_byte_packer.sv
`default_nettype none
// ============================================================================
//  Module      : sample_byte_packer
//  Description : Packs dual-channel 12-bit sample pairs into three bytes and
//                streams them on a valid/ready byte interface, buffering
//                samples across short output stalls and counting drops.
//  Revision    : 1.0 - initial release
// ============================================================================
module sample_byte_packer
    import scope_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wire logic           clk,
    input  wire logic           reset,
    sample_byte_packer_if.slave bus
);

    logic                w_fifo_wr;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic [PACKED_W-1:0] w_fifo_wr_data;
    logic [PACKED_W-1:0] w_fifo_rd_data;
    logic                w_pop;
    logic                w_handshake;
    logic                w_drop;

    ser_state_t          r_state;
    ser_state_t          w_state_n;
    logic [PACKED_W-1:0] r_hold;
    logic [PACKED_W-1:0] w_hold_n;
    logic [7:0]          r_out_data;
    logic [7:0]          w_out_data_n;
    logic                r_out_valid;
    logic                r_overflow;
    logic [7:0]          r_drop_count;

    assign w_fifo_wr_data = pack(bus.data_ch1, bus.data_ch2);
    assign w_handshake    = r_out_valid && bus.out_ready;
    // A pop in the same cycle frees the slot, so a full buffer still accepts.
    assign w_fifo_wr      = bus.sample_valid && (!w_fifo_full || w_pop);
    assign w_drop         = bus.sample_valid && w_fifo_full && !w_pop;

    sample_fifo #(
        .WIDTH (PACKED_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (w_fifo_wr),
        .wr_data (w_fifo_wr_data),
        .rd_en   (w_pop),
        .rd_data (w_fifo_rd_data),
        .full    (w_fifo_full),
        .empty   (w_fifo_empty)
    );

    // Serializer next state, holding register load and next output byte.
    always_comb begin
        w_state_n    = r_state;
        w_hold_n     = r_hold;
        w_pop        = 1'b0;
        w_out_data_n = 8'h00;
        case (r_state)
            IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop     = 1'b1;
                    w_hold_n  = w_fifo_rd_data;
                    w_state_n = B0;
                end
            end
            B0: if (w_handshake) w_state_n = B1;
            B1: if (w_handshake) w_state_n = B2;
            B2: begin
                if (w_handshake) begin
                    // Reload straight into B0 so back-to-back samples leave no gap.
                    if (!w_fifo_empty) begin
                        w_pop     = 1'b1;
                        w_hold_n  = w_fifo_rd_data;
                        w_state_n = B0;
                    end else begin
                        w_state_n = IDLE;
                    end
                end
            end
            default: w_state_n = IDLE;
        endcase
        case (w_state_n)
            B0:      w_out_data_n = w_hold_n[PACKED_W-1 -: 8];
            B1:      w_out_data_n = w_hold_n[PACKED_W-9 -: 8];
            B2:      w_out_data_n = w_hold_n[7:0];
            default: w_out_data_n = 8'h00;
        endcase
    end

    // Serializer state, holding register and registered byte outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_hold      <= '0;
            r_out_data  <= 8'h00;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_hold      <= w_hold_n;
            r_out_data  <= w_out_data_n;
            r_out_valid <= (w_state_n != IDLE);
        end
    end

    // Sticky overflow flag and saturating drop counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow   <= 1'b0;
            r_drop_count <= 8'h00;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_count != 8'hFF) r_drop_count <= r_drop_count + 8'd1;
        end
    end

    assign bus.out_data   = r_out_data;
    assign bus.out_valid  = r_out_valid;
    assign bus.overflow   = r_overflow;
    assign bus.drop_count = r_drop_count;
    assign bus.busy       = !w_fifo_empty || (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sample_byte_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sample_byte_packer
//  Description : Directed self-checking bench for sample_byte_packer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sample_byte_packer;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [7:0] recv[$];
    logic [7:0] exp_q[$];

    sample_byte_packer_if bus ();

    sample_byte_packer #(.DEPTH(4)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop if the directed sequence ever stalls.
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Record a byte if it is handshaken at the coming edge, then advance one cycle.
    task automatic cyc();
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) recv.push_back(bus.out_data);
        @(negedge clk);
    endtask

    function automatic void add_exp(input logic [11:0] c1, input logic [11:0] c2);
        logic [23:0] w;
        w = {c1, c2};
        exp_q.push_back(w[23:16]);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[7:0]);
    endfunction

    task automatic compare_recv(input string tag);
        chk({tag, "_count"}, recv.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            chk(tag, (i < recv.size()) ? 32'(recv[i]) : 32'hxxxx_xxxx, 32'(exp_q[i]));
    endtask

    task automatic reset_dut();
        rst              = 1'b1;
        bus.sample_valid = 1'b0;
        bus.out_ready    = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
        recv.delete();
        exp_q.delete();
    endtask

    function automatic logic [11:0] st_c1(input int i);
        return 12'h111 * 12'(i + 1);
    endfunction

    function automatic logic [11:0] st_c2(input int i);
        return 12'h0A0 + 12'(i);
    endfunction

    initial begin
        checks           = 0;
        errors           = 0;
        rst              = 1'b1;
        bus.sample_valid = 1'b0;
        bus.data_ch1     = '0;
        bus.data_ch2     = '0;
        bus.out_ready    = 1'b0;
        @(negedge clk);

        // ---- reset state
        reset_dut();
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_data", bus.out_data, 0);
        chk("rst_ovf", bus.overflow, 0);
        chk("rst_drop", bus.drop_count, 0);
        chk("rst_busy", bus.busy, 0);

        // ---- single sample, latency N+2
        bus.out_ready    = 1'b1;
        bus.sample_valid = 1'b1;
        bus.data_ch1     = 12'hABC;
        bus.data_ch2     = 12'h123;
        cyc();
        bus.sample_valid = 1'b0;
        chk("s1_n1_valid", bus.out_valid, 0);
        chk("s1_n1_busy", bus.busy, 1);
        cyc();
        chk("s1_b0_valid", bus.out_valid, 1);
        chk("s1_b0", bus.out_data, 8'hAB);
        cyc();
        chk("s1_b1", bus.out_data, 8'hC1);
        cyc();
        chk("s1_b2", bus.out_data, 8'h23);
        cyc();
        chk("s1_end_valid", bus.out_valid, 0);
        chk("s1_end_busy", bus.busy, 0);

        // ---- back-to-back samples every 3 cycles
        begin
            logic [11:0] t2c1[3];
            logic [11:0] t2c2[3];
            t2c1 = '{12'h123, 12'hFED, 12'h800};
            t2c2 = '{12'h456, 12'hCBA, 12'h001};
            recv.delete();
            exp_q.delete();
            for (int k = 0; k < 12; k++) begin
                bus.sample_valid = (k % 3 == 0) && (k < 9);
                if (bus.sample_valid) begin
                    bus.data_ch1 = t2c1[k/3];
                    bus.data_ch2 = t2c2[k/3];
                    add_exp(t2c1[k/3], t2c2[k/3]);
                end
                if (k >= 2 && k <= 10) chk("b2b_nobubble", bus.out_valid, 1);
                cyc();
            end
            compare_recv("b2b_bytes");
            chk("b2b_drop", bus.drop_count, 0);
        end

        // ---- stall: 6 samples into DEPTH=4, one dropped
        reset_dut();
        for (int k = 0; k < 18; k++) begin
            bus.sample_valid = (k % 3 == 0) && (k <= 15);
            if (bus.sample_valid) begin
                bus.data_ch1 = st_c1(k/3);
                bus.data_ch2 = st_c2(k/3);
                if (k/3 < 5) add_exp(st_c1(k/3), st_c2(k/3));
            end
            if (k == 8) begin
                chk("stall_valid", bus.out_valid, 1);
                chk("stall_hold", bus.out_data, 8'h11);
            end
            if (k == 13) chk("stall_ovf_before", bus.overflow, 0);
            if (k == 16) begin
                chk("stall_ovf", bus.overflow, 1);
                chk("stall_drop", bus.drop_count, 1);
            end
            cyc();
        end
        bus.sample_valid = 1'b0;
        bus.out_ready    = 1'b1;
        for (int c = 0; c < 40; c++) cyc();
        compare_recv("stall_bytes");
        chk("stall_ovf_after", bus.overflow, 1);
        chk("stall_drop_after", bus.drop_count, 1);
        chk("stall_busy_after", bus.busy, 0);

        // ---- backpressure in B1 for 7 cycles
        reset_dut();
        add_exp(12'h9A5, 12'h3C7);
        bus.data_ch1 = 12'h9A5;
        bus.data_ch2 = 12'h3C7;
        for (int k = 0; k < 13; k++) begin
            bus.sample_valid = (k == 0);
            bus.out_ready    = !(k >= 3 && k <= 9);
            if (k == 2) chk("bp_b0", bus.out_data, 8'h9A);
            if (k >= 3 && k <= 10) begin
                chk("bp_hold_valid", bus.out_valid, 1);
                chk("bp_hold_b1", bus.out_data, 8'h53);
            end
            if (k == 11) chk("bp_b2", bus.out_data, 8'hC7);
            if (k == 12) chk("bp_end_valid", bus.out_valid, 0);
            cyc();
        end
        compare_recv("bp_bytes");

        // ---- full buffer with simultaneous pop
        reset_dut();
        for (int k = 0; k < 17; k++) begin
            bus.sample_valid = ((k % 3 == 0) && (k <= 12)) || (k == 16);
            bus.out_ready    = (k >= 14);
            if (bus.sample_valid) begin
                int idx;
                idx = (k == 16) ? 5 : k / 3;
                bus.data_ch1 = 12'hA00 + 12'(idx);
                bus.data_ch2 = 12'h0B0 + 12'(idx);
                add_exp(12'hA00 + 12'(idx), 12'h0B0 + 12'(idx));
            end
            if (k == 16) chk("fp_in_b2", bus.out_data, 8'hB0);
            cyc();
        end
        bus.sample_valid = 1'b0;
        chk("fp_drop", bus.drop_count, 0);
        chk("fp_ovf", bus.overflow, 0);
        for (int c = 0; c < 40; c++) cyc();
        compare_recv("fp_bytes");

        // ---- reset during B2 with 3 entries buffered
        reset_dut();
        for (int k = 0; k < 23; k++) begin
            bus.sample_valid = (k % 3 == 0) && (k <= 15);
            bus.out_ready    = (k >= 17) && (k <= 21);
            if (bus.sample_valid) begin
                bus.data_ch1 = st_c1(k/3);
                bus.data_ch2 = st_c2(k/3);
            end
            if (k == 16) begin
                chk("mr_ovf_pre", bus.overflow, 1);
                chk("mr_drop_pre", bus.drop_count, 1);
            end
            if (k == 22) begin
                chk("mr_b2_valid", bus.out_valid, 1);
                chk("mr_b2_data", bus.out_data, 8'hA1);
                rst              = 1'b1;
                bus.sample_valid = 1'b1;
                bus.out_ready    = 1'b0;
            end
            cyc();
        end
        chk("mr_valid", bus.out_valid, 0);
        chk("mr_data", bus.out_data, 0);
        chk("mr_ovf", bus.overflow, 0);
        chk("mr_drop", bus.drop_count, 0);
        chk("mr_busy", bus.busy, 0);
        rst              = 1'b0;
        bus.sample_valid = 1'b0;
        cyc();
        chk("mr_idle_busy", bus.busy, 0);
        recv.delete();
        exp_q.delete();
        add_exp(12'h5E1, 12'h7F2);
        bus.data_ch1  = 12'h5E1;
        bus.data_ch2  = 12'h7F2;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            bus.sample_valid = (k == 0);
            if (k == 2) chk("mr_new_b0", bus.out_data, 8'h5E);
            cyc();
        end
        compare_recv("mr_new_bytes");
        chk("mr_new_busy", bus.busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
